// File: rtl/jump_hazard_sequencer_if.sv
// Handshake bundle between hazard/decode logic and the jump sequencer.
// The master modport is the upstream pipeline side and the slave modport is the sequencer.
interface jump_hazard_sequencer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              stall;
  logic              jmp_req;
  logic [ADDR_W-1:0] jmp_target;
  logic              stall_out;
  logic              take_jmp;
  logic [ADDR_W-1:0] jmp_pc;
  logic              nop;
  logic              stall_jump;
  logic              busy;

  modport master (
    output stall, jmp_req, jmp_target,
    input  stall_out, take_jmp, jmp_pc, nop, stall_jump, busy
  );

  modport slave (
    input  stall, jmp_req, jmp_target,
    output stall_out, take_jmp, jmp_pc, nop, stall_jump, busy
  );
endinterface

// File: rtl/jump_hazard_sequencer.sv
// Sequences a jump through HOLD (load-use stall), TAKE, FLUSH bubbles and a release pulse.
// All outputs are Moore-decoded from the registered state.
module jump_hazard_sequencer #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned LU_STALL     = 1,
  parameter int unsigned FLUSH_DEPTH  = 0,
  parameter bit          JMP_NO_STALL = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  jump_hazard_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    TAKE    = 3'd2,
    FLUSH   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] jmp_pc_q, jmp_pc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      jmp_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      jmp_pc_q <= jmp_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    jmp_pc_d = jmp_pc_q;
    case (state_q)
      IDLE: begin
        if (bus.jmp_req && bus.stall) begin
          state_d  = HOLD;
          cnt_d    = 4'(LU_STALL - 1);
          jmp_pc_d = bus.jmp_target;
        end else if (bus.jmp_req && JMP_NO_STALL) begin
          state_d  = TAKE;
          jmp_pc_d = bus.jmp_target;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = TAKE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      TAKE: begin
        if (FLUSH_DEPTH > 0) begin
          state_d = FLUSH;
          cnt_d   = 4'(FLUSH_DEPTH - 1);
        end else begin
          state_d = RELEASE;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = RELEASE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      RELEASE: state_d = IDLE;
      // Unused encodings recover to IDLE; outputs decode to 0 below.
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic stall_out_o, take_jmp_o, nop_o, stall_jump_o, busy_o;

  always_comb begin
    stall_out_o  = 1'b0;
    take_jmp_o   = 1'b0;
    nop_o        = 1'b0;
    stall_jump_o = 1'b0;
    busy_o       = 1'b0;
    case (state_q)
      HOLD: begin
        stall_out_o = 1'b1;
        busy_o      = 1'b1;
      end
      TAKE: begin
        take_jmp_o = 1'b1;
        nop_o      = 1'b1;
        busy_o     = 1'b1;
      end
      FLUSH: begin
        nop_o  = 1'b1;
        busy_o = 1'b1;
      end
      RELEASE: begin
        stall_jump_o = 1'b1;
        busy_o       = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.stall_out  = stall_out_o;
  assign bus.take_jmp   = take_jmp_o;
  assign bus.nop        = nop_o;
  assign bus.stall_jump = stall_jump_o;
  assign bus.busy       = busy_o;
  assign bus.jmp_pc     = jmp_pc_q;

endmodule

// File: tb/tb_jump_hazard_sequencer.sv
// Directed bench for jump_hazard_sequencer across three parameter sets.
// Vectors pack {stall_out, take_jmp, nop, stall_jump, busy}.
module tb_jump_hazard_sequencer;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_pass;

  jump_hazard_sequencer_if #(.ADDR_W(16)) if0 ();
  jump_hazard_sequencer_if #(.ADDR_W(16)) if1 ();
  jump_hazard_sequencer_if #(.ADDR_W(16)) if2 ();

  jump_hazard_sequencer #(
    .ADDR_W(16), .LU_STALL(1), .FLUSH_DEPTH(0), .JMP_NO_STALL(1'b1)
  ) u_def (.clk(clk), .rst(rst), .bus(if0));

  jump_hazard_sequencer #(
    .ADDR_W(16), .LU_STALL(3), .FLUSH_DEPTH(2), .JMP_NO_STALL(1'b1)
  ) u_long (.clk(clk), .rst(rst), .bus(if1));

  jump_hazard_sequencer #(
    .ADDR_W(16), .LU_STALL(1), .FLUSH_DEPTH(0), .JMP_NO_STALL(1'b0)
  ) u_nojmp (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] vec0();
    return {if0.stall_out, if0.take_jmp, if0.nop, if0.stall_jump, if0.busy};
  endfunction
  function automatic logic [4:0] vec1();
    return {if1.stall_out, if1.take_jmp, if1.nop, if1.stall_jump, if1.busy};
  endfunction
  function automatic logic [4:0] vec2();
    return {if2.stall_out, if2.take_jmp, if2.nop, if2.stall_jump, if2.busy};
  endfunction

  // expected per-cycle vectors for LU_STALL=3, FLUSH_DEPTH=2 after the request edge
  logic [4:0] exp_long [8] = '{5'b10001, 5'b10001, 5'b10001, 5'b01101,
                               5'b00101, 5'b00101, 5'b00011, 5'b00000};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    if0.stall = 1'b0; if0.jmp_req = 1'b0; if0.jmp_target = '0;
    if1.stall = 1'b0; if1.jmp_req = 1'b0; if1.jmp_target = '0;
    if2.stall = 1'b0; if2.jmp_req = 1'b0; if2.jmp_target = '0;
    tick(); tick();
    check("rst_vec0", 32'(vec0()), 32'h0);
    check("rst_vec1", 32'(vec1()), 32'h0);
    check("rst_pc0", 32'(if0.jmp_pc), 32'h0);
    rst = 1'b1;
    tick();

    // asynchronous reset in the middle of HOLD
    if1.stall = 1'b1; if1.jmp_req = 1'b1; if1.jmp_target = 16'h5555;
    tick();
    if1.stall = 1'b0; if1.jmp_req = 1'b0;
    check("midhold_pre", 32'(vec1()), 32'b10001);
    #2 rst = 1'b0;
    #1;
    check("midhold_async_vec", 32'(vec1()), 32'h0);
    check("midhold_async_pc", 32'(if1.jmp_pc), 32'h0);
    tick();
    rst = 1'b1;
    tick(); tick(); tick(); tick();
    check("midhold_after_vec", 32'(vec1()), 32'h0);
    check("midhold_after_pc", 32'(if1.jmp_pc), 32'h0);

    // default parameters: stall + jump
    if0.stall = 1'b1; if0.jmp_req = 1'b1; if0.jmp_target = 16'h0040;
    tick();
    if0.stall = 1'b0; if0.jmp_req = 1'b0;
    check("def_c1", 32'(vec0()), 32'b10001);
    tick();
    check("def_c2", 32'(vec0()), 32'b01101);
    check("def_c2_pc", 32'(if0.jmp_pc), 32'h0040);
    tick();
    check("def_c3", 32'(vec0()), 32'b00011);
    tick();
    check("def_c4", 32'(vec0()), 32'b00000);
    check("def_c4_pc", 32'(if0.jmp_pc), 32'h0040);

    // long stall plus flush
    if1.stall = 1'b1; if1.jmp_req = 1'b1; if1.jmp_target = 16'h1234;
    tick();
    if1.stall = 1'b0; if1.jmp_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("long_c%0d", i + 1), 32'(vec1()), 32'(exp_long[i]));
      if (i == 3) check("long_pc", 32'(if1.jmp_pc), 32'h1234);
      tick();
    end

    // no-stall jump, enabled and disabled
    if0.jmp_req = 1'b1; if0.jmp_target = 16'h00FF;
    if2.jmp_req = 1'b1; if2.jmp_target = 16'h00FF;
    tick();
    if0.jmp_req = 1'b0; if2.jmp_req = 1'b0;
    check("ns_c1", 32'(vec0()), 32'b01101);
    check("ns_c1_pc", 32'(if0.jmp_pc), 32'h00FF);
    check("ns_off_c1", 32'(vec2()), 32'h0);
    tick();
    check("ns_c2", 32'(vec0()), 32'b00011);
    check("ns_off_c2", 32'(vec2()), 32'h0);
    tick();
    check("ns_c3", 32'(vec0()), 32'b00000);
    check("ns_off_pc", 32'(if2.jmp_pc), 32'h0);

    // requests during busy are ignored, re-presented in IDLE they are accepted
    if0.stall = 1'b1; if0.jmp_req = 1'b1; if0.jmp_target = 16'h0040;
    tick();
    if0.jmp_target = 16'h0BAD;
    check("busy_hold", 32'(vec0()), 32'b10001);
    tick();
    if0.stall = 1'b0; if0.jmp_req = 1'b0;
    check("busy_take", 32'(vec0()), 32'b01101);
    check("busy_take_pc", 32'(if0.jmp_pc), 32'h0040);
    tick();
    check("busy_rel", 32'(vec0()), 32'b00011);
    if0.stall = 1'b1; if0.jmp_req = 1'b1;
    tick();
    check("busy_idle", 32'(vec0()), 32'b00000);
    check("busy_idle_pc", 32'(if0.jmp_pc), 32'h0040);
    tick();
    if0.stall = 1'b0; if0.jmp_req = 1'b0;
    check("re_hold", 32'(vec0()), 32'b10001);
    check("re_hold_pc", 32'(if0.jmp_pc), 32'h0BAD);
    tick();
    check("re_take", 32'(vec0()), 32'b01101);
    tick();
    check("re_rel", 32'(vec0()), 32'b00011);
    tick();
    check("re_idle", 32'(vec0()), 32'b00000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jump_hazard_sequencer.md
Name: jump_hazard_sequencer

Overview:
- Parametrised controller that sequences a jump through the pipeline when it may coincide with a load-use stall.
- Holds the front end for a configurable number of stall cycles, then issues one take-jump cycle with the latched target.
- Then inserts a configurable number of NOP bubbles and finishes with a one-cycle stall_jump release pulse.
- Sits between the hazard detection unit, the decode-stage jump decode, and the fetch/PC-select logic.

Parameters:
- ADDR_W, 16, width of jump target / PC.
- LU_STALL, 1, number of stall_out cycles inserted when a jump meets a load-use stall (legal 1..15).
- FLUSH_DEPTH, 0, extra NOP cycles after the take cycle (legal 0..15).
- JMP_NO_STALL, 1, if 1 a jump without a concurrent stall is also sequenced (skipping the HOLD state); if 0 it is ignored.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  load-use stall request from hazard unit.
- jmp_req  in  1  unconditional jump decoded this cycle.
- jmp_target  in  ADDR_W  jump destination, valid with jmp_req.
- stall_out  out  1  freeze PC/IF-ID.
- take_jmp  out  1  select jmp_pc into PC.
- jmp_pc  out  ADDR_W  latched jump target.
- nop  out  1  inject bubble into ID/EX.
- stall_jump  out  1  one-cycle release pulse after the sequence.
- busy  out  1  sequencer not in IDLE.

Behaviour:
- States: IDLE, HOLD, TAKE, FLUSH, RELEASE.
- All outputs are decoded from registered state; they are Moore outputs with no combinational path from the inputs.
- rst=0, asynchronous: state=IDLE, counter=0, jmp_pc=0, and all 1-bit outputs are 0. This applies at any point, including mid-sequence. The sequence is abandoned and no release pulse is produced.
- IDLE:
  - stall=1 & jmp_req=1 at an edge -> HOLD. jmp_target is latched into jmp_pc and the counter is loaded with LU_STALL-1.
  - stall=0 & jmp_req=1 & JMP_NO_STALL=1 -> TAKE. jmp_pc is latched.
  - Otherwise stay in IDLE. stall alone is not acted on; the hazard unit drives its own stall path.
- HOLD: stall_out=1 and busy=1. Counter decrements each cycle; counter==0 -> TAKE. Lasts exactly LU_STALL cycles.
- TAKE: take_jmp=1, nop=1, busy=1, exactly one cycle.
  - FLUSH_DEPTH>0 -> FLUSH, counter=FLUSH_DEPTH-1.
  - FLUSH_DEPTH==0 -> RELEASE.
- FLUSH: nop=1 and busy=1 for FLUSH_DEPTH cycles, then -> RELEASE.
- RELEASE: stall_jump=1 and busy=1 for one cycle, then -> IDLE.
- Latency from the request edge: take_jmp rises LU_STALL cycles later (0 in the no-stall path). stall_jump follows take_jmp by 1+FLUSH_DEPTH cycles.
- Outputs in states where they are not listed are 0.
- jmp_pc holds its value until the next accepted request. It is updated only on the IDLE exit edge.
- While busy=1, jmp_req and stall are ignored: no re-latch and no restart. A request present in the same cycle that RELEASE is active is also ignored. The upstream pipeline must hold or re-present it once busy=0.
- A request is accepted in the first IDLE cycle after RELEASE, so back-to-back jumps are separated by at least one IDLE cycle.
- Counter width is 4 bits; decrement stops at 0, with no wrap.
- Illegal or unused state encoding -> IDLE on the next edge, with outputs 0.

Test Plan:
- Reset mid-HOLD: rst=0 asynchronously while stall_out=1 -> all outputs 0 immediately, without waiting for a clock edge. After release, busy=0 and jmp_pc=0.
- Defaults (LU_STALL=1, FLUSH_DEPTH=0): stall=1, jmp_req=1, jmp_target=16'h0040 for one edge.
  - Cycle 1: stall_out=1.
  - Cycle 2: take_jmp=1, nop=1, jmp_pc=0x0040.
  - Cycle 3: stall_jump=1.
  - Cycle 4: all outputs 0, busy=0.
- LU_STALL=3, FLUSH_DEPTH=2, target=0x1234: stall_out=1 for 3 cycles, take_jmp for 1, nop for 3 total (take cycle + 2 flush), then stall_jump for 1. busy high for 7 cycles.
- No-stall jump, JMP_NO_STALL=1: stall=0, jmp_req=1, target=0x00FF -> take_jmp=1 on the very next cycle, then stall_jump. With JMP_NO_STALL=0 the same stimulus leaves all outputs 0.
- Request during busy: a second jmp_req with target 0x0BAD, issued during HOLD and again during RELEASE -> jmp_pc stays 0x0040 and no second take_jmp occurs. Re-presenting the request in IDLE starts a new sequence with jmp_pc=0x0BAD.
